// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: FU identifiers, flag type and the FIFO entry carried to the broadcast bus.
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif

package cdb_arbiter_pkg;

    typedef logic [3:0] nzcv_t;

    typedef enum logic {
        FU_ALU = 1'b0,
        FU_LS  = 1'b1
    } fu_t;

    typedef struct packed {
        logic [`GPR_SIZE-1:0]     value;
        logic [`ROB_IDX_SIZE-1:0] rob_index;
        logic                     set_nzcv;
        nzcv_t                    nzcv;
    } cdb_entry_t;

    localparam int CDB_FIFO_DEPTH    = 2;
    localparam int CDB_FIFO_IDX_SIZE = 1;

    function automatic fu_t other_fu(input fu_t fu);
        return (fu == FU_ALU) ? FU_LS : FU_ALU;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-FU result FIFO. Ready reflects the registered count only, so a full FIFO refuses a push even while popping.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH    = CDB_FIFO_DEPTH,
    parameter int FIFO_IDX_SIZE = CDB_FIFO_IDX_SIZE
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_flush,
    input  logic       in_push,
    input  cdb_entry_t in_entry,
    input  logic       in_pop,
    output cdb_entry_t out_head,
    output logic       out_empty,
    output logic       out_ready
);

    localparam logic [FIFO_IDX_SIZE:0]   DEPTH_C   = (FIFO_IDX_SIZE+1)'(FIFO_DEPTH);
    localparam logic [FIFO_IDX_SIZE:0]   CNT_ONE_C = (FIFO_IDX_SIZE+1)'(1);
    localparam logic [FIFO_IDX_SIZE-1:0] PTR_ONE_C = FIFO_IDX_SIZE'(1);

    cdb_entry_t               mem_r [FIFO_DEPTH];
    logic [FIFO_IDX_SIZE-1:0] rd_ptr_r;
    logic [FIFO_IDX_SIZE-1:0] wr_ptr_r;
    logic [FIFO_IDX_SIZE:0]   count_r;
    logic                     push_ok_s;
    logic                     pop_ok_s;

    assign out_ready = ~in_rst & (count_r < DEPTH_C);
    assign out_empty = (count_r == {(FIFO_IDX_SIZE+1){1'b0}});
    assign out_head  = mem_r[rd_ptr_r];
    assign push_ok_s = in_push & out_ready & ~in_flush;
    assign pop_ok_s  = in_pop & ~out_empty & ~in_flush;

    // Entry storage: written at the write pointer on an accepted push.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= in_entry;
        end
    end

    // Pointers and occupancy; flush empties the FIFO and discards same-cycle pushes.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (in_flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter draining the ALU and LS result FIFOs onto a single registered CDB broadcast.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH    = CDB_FIFO_DEPTH,
    parameter int FIFO_IDX_SIZE = CDB_FIFO_IDX_SIZE
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_fu_alu_done,
    input  logic [`GPR_SIZE-1:0]     in_fu_alu_value,
    input  logic [`ROB_IDX_SIZE-1:0] in_fu_alu_dst_rob_index,
    input  logic                     in_fu_alu_set_nzcv,
    input  nzcv_t                    in_fu_alu_nzcv,
    input  logic                     in_fu_ls_done,
    input  logic [`GPR_SIZE-1:0]     in_fu_ls_value,
    input  logic [`ROB_IDX_SIZE-1:0] in_fu_ls_dst_rob_index,
    input  logic                     in_rob_stall,
    input  logic                     in_rob_is_mispred,
    output logic                     out_fu_alu_ready,
    output logic                     out_fu_ls_ready,
    output logic                     out_cdb_done,
    output logic [`ROB_IDX_SIZE-1:0] out_cdb_index,
    output logic [`GPR_SIZE-1:0]     out_cdb_value,
    output logic                     out_cdb_set_nzcv,
    output nzcv_t                    out_cdb_nzcv,
    output fu_t                      out_cdb_src
);

    cdb_entry_t alu_entry_s;
    cdb_entry_t ls_entry_s;
    cdb_entry_t alu_head_s;
    cdb_entry_t ls_head_s;
    logic       alu_empty_s;
    logic       ls_empty_s;
    logic       grant_valid_s;
    fu_t        grant_src_s;
    logic       grant_fire_s;
    logic       pop_alu_s;
    logic       pop_ls_s;
    fu_t        last_grant_r;
    logic       cdb_done_r;
    cdb_entry_t cdb_r;
    fu_t        cdb_src_r;

    assign alu_entry_s = '{value:     in_fu_alu_value,
                           rob_index: in_fu_alu_dst_rob_index,
                           set_nzcv:  in_fu_alu_set_nzcv,
                           nzcv:      in_fu_alu_nzcv};
    assign ls_entry_s  = '{value:     in_fu_ls_value,
                           rob_index: in_fu_ls_dst_rob_index,
                           set_nzcv:  1'b0,
                           nzcv:      4'b0000};

    cdb_fifo #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .FIFO_IDX_SIZE (FIFO_IDX_SIZE)
    ) u_alu_fifo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_flush  (in_rob_is_mispred),
        .in_push   (in_fu_alu_done),
        .in_entry  (alu_entry_s),
        .in_pop    (pop_alu_s),
        .out_head  (alu_head_s),
        .out_empty (alu_empty_s),
        .out_ready (out_fu_alu_ready)
    );

    cdb_fifo #(
        .FIFO_DEPTH    (FIFO_DEPTH),
        .FIFO_IDX_SIZE (FIFO_IDX_SIZE)
    ) u_ls_fifo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_flush  (in_rob_is_mispred),
        .in_push   (in_fu_ls_done),
        .in_entry  (ls_entry_s),
        .in_pop    (pop_ls_s),
        .out_head  (ls_head_s),
        .out_empty (ls_empty_s),
        .out_ready (out_fu_ls_ready)
    );

    // Winner selection: a sole candidate wins, a tie goes to the FU that did not win last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_src_s   = FU_ALU;
        case ({~alu_empty_s, ~ls_empty_s})
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_src_s   = other_fu(last_grant_r);
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_src_s   = FU_ALU;
            end
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_src_s   = FU_LS;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_src_s   = FU_ALU;
            end
        endcase
    end

    assign grant_fire_s = grant_valid_s & ~in_rob_stall & ~in_rob_is_mispred;
    assign pop_alu_s    = grant_fire_s & (grant_src_s == FU_ALU);
    assign pop_ls_s     = grant_fire_s & (grant_src_s == FU_LS);

    // Broadcast register and round-robin history; stall freezes both, mispredict kills the pulse.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            cdb_done_r   <= 1'b0;
            cdb_r        <= '0;
            cdb_src_r    <= FU_ALU;
            last_grant_r <= FU_LS;
        end else if (in_rob_is_mispred) begin
            cdb_done_r <= 1'b0;
        end else if (in_rob_stall) begin
            cdb_done_r <= cdb_done_r;
        end else if (grant_valid_s) begin
            cdb_done_r   <= 1'b1;
            cdb_r        <= (grant_src_s == FU_ALU) ? alu_head_s : ls_head_s;
            cdb_src_r    <= grant_src_s;
            last_grant_r <= grant_src_s;
        end else begin
            cdb_done_r <= 1'b0;
        end
    end

    assign out_cdb_done     = cdb_done_r;
    assign out_cdb_index    = cdb_r.rob_index;
    assign out_cdb_value    = cdb_r.value;
    assign out_cdb_set_nzcv = cdb_r.set_nzcv;
    assign out_cdb_nzcv     = cdb_r.nzcv;
    assign out_cdb_src      = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic                     in_clk = 1'b0;
    logic                     in_rst = 1'b1;
    logic                     in_fu_alu_done = 1'b0;
    logic [`GPR_SIZE-1:0]     in_fu_alu_value = '0;
    logic [`ROB_IDX_SIZE-1:0] in_fu_alu_dst_rob_index = '0;
    logic                     in_fu_alu_set_nzcv = 1'b0;
    nzcv_t                    in_fu_alu_nzcv = 4'b0000;
    logic                     in_fu_ls_done = 1'b0;
    logic [`GPR_SIZE-1:0]     in_fu_ls_value = '0;
    logic [`ROB_IDX_SIZE-1:0] in_fu_ls_dst_rob_index = '0;
    logic                     in_rob_stall = 1'b0;
    logic                     in_rob_is_mispred = 1'b0;
    logic                     out_fu_alu_ready;
    logic                     out_fu_ls_ready;
    logic                     out_cdb_done;
    logic [`ROB_IDX_SIZE-1:0] out_cdb_index;
    logic [`GPR_SIZE-1:0]     out_cdb_value;
    logic                     out_cdb_set_nzcv;
    nzcv_t                    out_cdb_nzcv;
    fu_t                      out_cdb_src;

    cdb_arbiter dut (
        .in_clk                  (in_clk),
        .in_rst                  (in_rst),
        .in_fu_alu_done          (in_fu_alu_done),
        .in_fu_alu_value         (in_fu_alu_value),
        .in_fu_alu_dst_rob_index (in_fu_alu_dst_rob_index),
        .in_fu_alu_set_nzcv      (in_fu_alu_set_nzcv),
        .in_fu_alu_nzcv          (in_fu_alu_nzcv),
        .in_fu_ls_done           (in_fu_ls_done),
        .in_fu_ls_value          (in_fu_ls_value),
        .in_fu_ls_dst_rob_index  (in_fu_ls_dst_rob_index),
        .in_rob_stall            (in_rob_stall),
        .in_rob_is_mispred       (in_rob_is_mispred),
        .out_fu_alu_ready        (out_fu_alu_ready),
        .out_fu_ls_ready         (out_fu_ls_ready),
        .out_cdb_done            (out_cdb_done),
        .out_cdb_index           (out_cdb_index),
        .out_cdb_value           (out_cdb_value),
        .out_cdb_set_nzcv        (out_cdb_set_nzcv),
        .out_cdb_nzcv            (out_cdb_nzcv),
        .out_cdb_src             (out_cdb_src)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [63:0] value;
        logic [63:0] index;
        logic        set_nzcv;
        logic [3:0]  nzcv;
    } res_t;

    res_t alu_q[$];
    res_t ls_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model of the visible broadcast state.
    logic        m_done;
    logic [63:0] m_index;
    logic [63:0] m_value;
    logic        m_set;
    logic [3:0]  m_nzcv;
    fu_t         m_src;
    fu_t         m_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        alu_q.delete();
        ls_q.delete();
        m_done  = 1'b0;
        m_index = '0;
        m_value = '0;
        m_set   = 1'b0;
        m_nzcv  = 4'b0000;
        m_src   = FU_ALU;
        m_last  = FU_LS;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".done"},  64'(out_cdb_done), 64'(m_done));
        check({tag, ".index"}, 64'(out_cdb_index), m_index);
        check({tag, ".value"}, out_cdb_value, m_value);
        check({tag, ".set"},   64'(out_cdb_set_nzcv), 64'(m_set));
        check({tag, ".nzcv"},  64'(out_cdb_nzcv), 64'(m_nzcv));
        check({tag, ".src"},   64'(out_cdb_src), 64'(m_src));
        check({tag, ".alu_rdy"}, 64'(out_fu_alu_ready), 64'(!in_rst && alu_q.size() < DEPTH));
        check({tag, ".ls_rdy"},  64'(out_fu_ls_ready),  64'(!in_rst && ls_q.size() < DEPTH));
    endtask

    // Applies one clock with the currently driven inputs to both model and DUT, then compares.
    task automatic cycle(input string tag);
        bit   alu_ok, ls_ok;
        int   win;
        res_t e;
        if (in_rst) begin
            model_reset();
        end else begin
            alu_ok = alu_q.size() < DEPTH;
            ls_ok  = ls_q.size() < DEPTH;
            if (in_rob_is_mispred) begin
                alu_q.delete();
                ls_q.delete();
                m_done = 1'b0;
            end else begin
                if (!in_rob_stall) begin
                    win = -1;
                    if (alu_q.size() > 0 && ls_q.size() > 0) win = (m_last == FU_ALU) ? 1 : 0;
                    else if (alu_q.size() > 0) win = 0;
                    else if (ls_q.size() > 0) win = 1;
                    if (win < 0) begin
                        m_done = 1'b0;
                    end else begin
                        e = (win == 0) ? alu_q.pop_front() : ls_q.pop_front();
                        m_done  = 1'b1;
                        m_index = e.index;
                        m_value = e.value;
                        m_set   = e.set_nzcv;
                        m_nzcv  = e.nzcv;
                        m_src   = (win == 0) ? FU_ALU : FU_LS;
                        m_last  = m_src;
                    end
                end
                if (in_fu_alu_done && alu_ok)
                    alu_q.push_back('{64'(in_fu_alu_value), 64'(in_fu_alu_dst_rob_index),
                                      in_fu_alu_set_nzcv, in_fu_alu_nzcv});
                if (in_fu_ls_done && ls_ok)
                    ls_q.push_back('{64'(in_fu_ls_value), 64'(in_fu_ls_dst_rob_index),
                                     1'b0, 4'b0000});
            end
        end
        @(posedge in_clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        in_fu_alu_done    = 1'b0;
        in_fu_ls_done     = 1'b0;
        in_rob_stall      = 1'b0;
        in_rob_is_mispred = 1'b0;
    endtask

    task automatic alu_push(input logic [63:0] v, input logic [3:0] idx, input logic s, input logic [3:0] n);
        in_fu_alu_done          = 1'b1;
        in_fu_alu_value         = v;
        in_fu_alu_dst_rob_index = idx;
        in_fu_alu_set_nzcv      = s;
        in_fu_alu_nzcv          = n;
    endtask

    task automatic ls_push(input logic [63:0] v, input logic [3:0] idx);
        in_fu_ls_done          = 1'b1;
        in_fu_ls_value         = v;
        in_fu_ls_dst_rob_index = idx;
    endtask

    initial begin
        model_reset();
        #1;
        compare_all("reset");
        #12;
        in_rst = 1'b0;
        cycle("post_reset");

        // Single ALU result broadcasts two edges after it is driven.
        alu_push(64'd42, 4'd5, 1'b1, 4'b0100);
        cycle("alu1_push");
        idle_inputs();
        cycle("alu1_bcast");
        check("alu1_done_const",  64'(out_cdb_done), 64'd1);
        check("alu1_value_const", out_cdb_value, 64'd42);
        check("alu1_index_const", 64'(out_cdb_index), 64'd5);
        cycle("alu1_after");
        check("alu1_pulse_const", 64'(out_cdb_done), 64'd0);

        // Simultaneous pushes: 1,2 then 3,4, broadcast in alternation.
        alu_push(64'd100, 4'd1, 1'b0, 4'b0000);
        ls_push(64'd200, 4'd2);
        cycle("sim_p1");
        alu_push(64'd300, 4'd3, 1'b1, 4'b1001);
        ls_push(64'd400, 4'd4);
        cycle("sim_p2");
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("sim_drain");

        // Backpressure: LS pushes three under stall, the third is dropped.
        in_rob_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ls_push(64'(500 + i), 4'(8 + i));
            cycle("bp_push");
        end
        check("bp_ready_const", 64'(out_fu_ls_ready), 64'd0);
        idle_inputs();
        for (int i = 0; i < 4; i++) cycle("bp_drain");

        // Stall hold over a live broadcast of idx 7.
        alu_push(64'd700, 4'd7, 1'b1, 4'b0010);
        cycle("hold_p1");
        alu_push(64'd800, 4'd8, 1'b0, 4'b0000);
        cycle("hold_p2");
        idle_inputs();
        in_rob_stall = 1'b1;
        for (int i = 0; i < 3; i++) cycle("hold_stall");
        check("hold_index_const", 64'(out_cdb_index), 64'd7);
        in_rob_stall = 1'b0;
        cycle("hold_release");
        cycle("hold_idle");

        // Mispredict with 2 ALU + 1 LS pending and a concurrent ALU push (stall also high).
        in_rob_stall = 1'b1;
        alu_push(64'd11, 4'd11, 1'b0, 4'b0000);
        ls_push(64'd12, 4'd12);
        cycle("mp_fill1");
        in_fu_ls_done = 1'b0;
        alu_push(64'd13, 4'd13, 1'b0, 4'b0000);
        cycle("mp_fill2");
        alu_push(64'd14, 4'd14, 1'b0, 4'b0000);
        in_rob_is_mispred = 1'b1;
        cycle("mp_flush");
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("mp_after");

        // Random traffic, including protocol-error pushes while not ready.
        for (int i = 0; i < 1500; i++) begin
            in_fu_alu_done          = ($urandom_range(0, 99) < 55);
            in_fu_alu_value         = {$urandom, $urandom};
            in_fu_alu_dst_rob_index = 4'($urandom);
            in_fu_alu_set_nzcv      = 1'($urandom);
            in_fu_alu_nzcv          = 4'($urandom);
            in_fu_ls_done           = ($urandom_range(0, 99) < 55);
            in_fu_ls_value          = {$urandom, $urandom};
            in_fu_ls_dst_rob_index  = 4'($urandom);
            in_rob_stall            = ($urandom_range(0, 99) < 25);
            in_rob_is_mispred       = ($urandom_range(0, 99) < 3);
            cycle("rand");
        end

        // Asynchronous reset mid-stream with both FIFOs full.
        idle_inputs();
        alu_push(64'd21, 4'd1, 1'b1, 4'b1111);
        ls_push(64'd22, 4'd2);
        cycle("rst_fill0");
        in_rob_stall = 1'b1;
        cycle("rst_fill1");
        cycle("rst_fill2");
        idle_inputs();
        #2;
        in_rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst_async");
        cycle("rst_hold");
        #2;
        in_rst = 1'b0;
        cycle("rst_release");
        cycle("rst_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
